cmp_slice_sched: RTL and testbench



---
 rtl/cmp_slice_sched.sv | 138 +++++++++++++
 tb/tb_cmp_slice_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_slice_sched.sv
// Sequences one shared 2-bit equality comparator slice across two WIDTH-bit operands, LSB slice first.
// Optional early exit on the first mismatching slice: define CMP_SLICE_EARLY_EXIT_EN.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on an accepted start
//   CMP   | one slice per clock driven on slc_a/slc_b, slc_eq folded in
//   DONE  | one-cycle done pulse; eq/miss_idx valid and held afterwards
module cmp_slice_sched #(
    parameter int WIDTH = 8,
    localparam int N_SLICES = WIDTH / 2,
    localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       slc_a,
    output logic [1:0]       slc_b,
    input  logic             slc_eq,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic [IW-1:0]    miss_idx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_SLICES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             acc_q, acc_d;
    logic [IW-1:0]    first_miss_q, first_miss_d;
    logic             eq_q, eq_d;
    logic [IW-1:0]    miss_idx_q, miss_idx_d;

    logic [IW:0]      bit_sel;
    logic             last_slice;
    logic             leave_cmp;

    assign bit_sel    = {idx_q, 1'b0};
    assign last_slice = (idx_q == LAST_IDX);

`ifdef CMP_SLICE_EARLY_EXIT_EN
    assign leave_cmp = last_slice || !slc_eq;
`else
    assign leave_cmp = last_slice;
`endif

    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        first_miss_d = first_miss_q;
        eq_d         = eq_q;
        miss_idx_d   = miss_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d         = a;
                    rb_d         = b;
                    idx_d        = '0;
                    acc_d        = 1'b1;
                    first_miss_d = '0;
                    eq_d         = 1'b0;
                    miss_idx_d   = '0;
                    state_d      = ST_CMP;
                end
            end
            ST_CMP: begin
                acc_d = acc_q & slc_eq;
                // acc_q still high means no earlier slice has missed
                if (acc_q && !slc_eq) begin
                    first_miss_d = idx_q;
                end
                if (leave_cmp) begin
                    eq_d       = acc_d;
                    miss_idx_d = acc_d ? '0 : first_miss_d;
                    state_d    = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ra_q         <= '0;
            rb_q         <= '0;
            idx_q        <= '0;
            acc_q        <= 1'b0;
            first_miss_q <= '0;
            eq_q         <= 1'b0;
            miss_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            first_miss_q <= first_miss_d;
            eq_q         <= eq_d;
            miss_idx_q   <= miss_idx_d;
        end
    end

    always_comb begin
        slc_a = 2'b00;
        slc_b = 2'b00;
        if (state_q == ST_CMP) begin
            slc_a = ra_q[bit_sel +: 2];
            slc_b = rb_q[bit_sel +: 2];
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign eq       = eq_q;
    assign miss_idx = miss_idx_q;

endmodule

// File: tb/tb_cmp_slice_sched.sv
// Directed bench for cmp_slice_sched (WIDTH=8) with an ideal 2-bit equality comparator on the slice bus.
module tb_cmp_slice_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] slc_a;
    logic [1:0] slc_b;
    logic       slc_eq;
    logic       busy;
    logic       done;
    logic       eq;
    logic [1:0] miss_idx;

    int tests;
    int fails;

    cmp_slice_sched #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .slc_a    (slc_a),
        .slc_b    (slc_b),
        .slc_eq   (slc_eq),
        .busy     (busy),
        .done     (done),
        .eq       (eq),
        .miss_idx (miss_idx)
    );

    assign slc_eq = (slc_a == slc_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input bit is_eq, input int miss);
`ifdef CMP_SLICE_EARLY_EXIT_EN
        return is_eq ? 5 : miss + 2;
`else
        return 5;
`endif
    endfunction

    // Starts a compare in the current cycle, optionally alters a one cycle later,
    // then checks latency, verdict and the single-cycle done pulse.
    task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] a_late, input bit exp_eq, input int exp_miss);
        int cnt;
        start = 1'b1;
        a = av;
        b = bv;
        step();
        start = 1'b0;
        a = a_late;
        cnt = 1;
        while (done !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cnt), 32'(exp_latency(exp_eq, exp_miss)));
        check({tag, " eq"}, 32'(eq), 32'(exp_eq));
        check({tag, " miss_idx"}, 32'(miss_idx), 32'(exp_miss));
        step();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " eq_held"}, 32'(eq), 32'(exp_eq));
    endtask

    initial begin
        int done_cnt;
        logic [1:0] exp_slc [4];
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst eq", 32'(eq), 32'd0);
        check("rst miss", 32'(miss_idx), 32'd0);
        check("rst slc", 32'({slc_a, slc_b}), 32'd0);
        rst_n = 1'b1;
        step();

        // Equal operands, slice walk 01,01,10,10
        exp_slc[0] = 2'b01;
        exp_slc[1] = 2'b01;
        exp_slc[2] = 2'b10;
        exp_slc[3] = 2'b10;
        start = 1'b1;
        a = 8'hA5;
        b = 8'hA5;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1 slc_a[%0d]", i), 32'(slc_a), 32'(exp_slc[i]));
            check($sformatf("t1 slc_b[%0d]", i), 32'(slc_b), 32'(exp_slc[i]));
            check($sformatf("t1 busy[%0d]", i), 32'(busy), 32'd1);
            check($sformatf("t1 nodone[%0d]", i), 32'(done), 32'd0);
            step();
        end
        check("t1 done", 32'(done), 32'd1);
        check("t1 eq", 32'(eq), 32'd1);
        check("t1 miss", 32'(miss_idx), 32'd0);
        check("t1 slc_idle", 32'({slc_a, slc_b}), 32'd0);
        step();
        check("t1 done_pulse", 32'(done), 32'd0);

        run_cmp("t2", 8'hA5, 8'h95, 8'hA5, 1'b0, 2);
        run_cmp("t3", 8'h00, 8'hFF, 8'h00, 1'b0, 0);
        run_cmp("last", 8'h00, 8'hC0, 8'h00, 1'b0, 3);
        run_cmp("mid", 8'h04, 8'h00, 8'h04, 1'b0, 1);

        // Starts while busy (in CMP and in DONE) must be ignored
        start = 1'b1;
        a = 8'h3C;
        b = 8'h3C;
        step();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                a = 8'h00;
                b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) done_cnt++;
            if (i < 5) step();
        end
        check("t4 one_done", 32'(done_cnt), 32'd1);
        check("t4 done_at_5", 32'(done), 32'd1);
        check("t4 eq", 32'(eq), 32'd1);
        start = 1'b1;
        a = 8'h00;
        b = 8'hFF;
        step();
        check("t4 done_start_ignored", 32'(busy), 32'd0);
        run_cmp("t4b", 8'h12, 8'h12, 8'h12, 1'b1, 0);

        // Reset mid-compare
        start = 1'b1;
        a = 8'hF0;
        b = 8'hF0;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 done", 32'(done), 32'd0);
        check("t5 eq", 32'(eq), 32'd0);
        check("t5 slc", 32'({slc_a, slc_b}), 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("t5 no_done", 32'(done_cnt), 32'd0);

        run_cmp("t6", 8'h5A, 8'h5A, 8'hFF, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
